cp0_timer_intc: RTL and testbench

//   Parametrised CP0 timer and interrupt front-end for the dual-issue core.

---
 rtl/cp0_timer_intc.sv | 132 +++++++++++++
 tb/tb_cp0_timer_intc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer and interrupt front-end: owns Count, Compare, Cause.TI
// and Cause.IP, synchronises hw interrupt lines, and registers the interrupt request.
module cp0_timer_intc #(
  parameter int unsigned HW_INT_NUM  = 6,
  parameter int unsigned SW_INT_NUM  = 2,
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMER_IP    = 7,
  localparam int unsigned IP_W       = SW_INT_NUM + HW_INT_NUM,
  localparam int unsigned IDX_W      = $clog2(IP_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [IP_W-1:0]       status_im,
  input  logic                  status_ie,
  input  logic                  status_exl,
  output logic [31:0]           count_o,
  output logic [31:0]           compare_o,
  output logic                  ti_o,
  output logic [IP_W-1:0]       cause_ip_o,
  output logic                  int_req,
  output logic [IDX_W-1:0]      int_idx
);

  localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;

  logic [31:0]           count_q;
  logic [31:0]           compare_q;
  logic [DIV_W-1:0]      div_q;
  logic                  ti_q;
  logic [SW_INT_NUM-1:0] sw_ip_q;
  logic [HW_INT_NUM-1:0] sync_q [SYNC_STAGES];

  logic        tick;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_cause;
  logic [31:0] count_inc;

  assign tick       = (div_q == DIV_W'(COUNT_DIV - 1));
  assign wr_count   = we && (waddr == ADDR_COUNT);
  assign wr_compare = we && (waddr == ADDR_COMPARE);
  assign wr_cause   = we && (waddr == ADDR_CAUSE);
  assign count_inc  = count_q + 32'd1;

  // Prescaler and Count; a COUNT write restarts the prescaler and beats the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      div_q   <= '0;
    end else if (wr_count) begin
      count_q <= wdata;
      div_q   <= '0;
    end else begin
      if (tick) count_q <= count_inc;
      div_q <= tick ? '0 : div_q + DIV_W'(1);
    end
  end

  // Compare and sticky TI; a COMPARE write clears TI even on a matching tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else if (wr_compare) begin
      compare_q <= wdata;
      ti_q      <= 1'b0;
    end else if (tick && !wr_count && (count_inc == compare_q)) begin
      ti_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_ip_q <= '0;
    end else if (wr_cause) begin
      sw_ip_q <= wdata[8 +: SW_INT_NUM];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [IP_W-1:0]  cause_ip_c;
  logic [IP_W-1:0]  pend_c;
  logic [IDX_W-1:0] idx_c;

  always_comb begin
    cause_ip_c           = {sync_q[SYNC_STAGES-1], sw_ip_q};
    cause_ip_c[TIMER_IP] = cause_ip_c[TIMER_IP] | ti_q;
  end

  assign pend_c = cause_ip_c & status_im;

  // Highest pending index wins; later loop iterations override earlier ones
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < IP_W; i++) begin
      if (pend_c[i]) idx_c = IDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_req <= 1'b0;
      int_idx <= '0;
    end else begin
      int_req <= (|pend_c) & status_ie & ~status_exl;
      int_idx <= idx_c;
    end
  end

  assign count_o    = count_q;
  assign compare_o  = compare_q;
  assign ti_o       = ti_q;
  assign cause_ip_o = cause_ip_c;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Scoreboard bench for cp0_timer_intc: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_timer_intc;

  localparam int unsigned IP_W  = 8;
  localparam int unsigned IDX_W = 3;

  localparam int F_COUNT = 0, F_COMPARE = 1, F_TI = 2, F_IP = 3, F_REQ = 4, F_IDX = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       hw_int;
  logic             we;
  logic [4:0]       waddr;
  logic [31:0]      wdata;
  logic [IP_W-1:0]  status_im;
  logic             status_ie;
  logic             status_exl;
  logic [31:0]      count_o;
  logic [31:0]      compare_o;
  logic             ti_o;
  logic [IP_W-1:0]  cause_ip_o;
  logic             int_req;
  logic [IDX_W-1:0] int_idx;

  cp0_timer_intc dut (
    .clk        (clk),
    .rst        (rst),
    .hw_int     (hw_int),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .status_im  (status_im),
    .status_ie  (status_ie),
    .status_exl (status_exl),
    .count_o    (count_o),
    .compare_o  (compare_o),
    .ti_o       (ti_o),
    .cause_ip_o (cause_ip_o),
    .int_req    (int_req),
    .int_idx    (int_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      F_COUNT:   return count_o;
      F_COMPARE: return compare_o;
      F_TI:      return 32'(ti_o);
      F_IP:      return 32'(cause_ip_o);
      F_REQ:     return 32'(int_req);
      default:   return 32'(int_idx);
    endcase
  endfunction

  // Monitor: outputs are settled half a cycle after the edge that produced them
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] a;
      e = q.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, a, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step(1);
    we = 1'b0; waddr = '0; wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; hw_int = '0; we = 1'b0; waddr = '0; wdata = '0;
    status_im = '0; status_ie = 1'b0; status_exl = 1'b0;

    step(2);
    expect_val("reset_count", F_COUNT, 32'h0);
    expect_val("reset_req",   F_REQ,   32'h0);
    step(1);
    rst = 1'b0;

    // Build count=0x1234 with ti=1, then pulse rst between edges
    cp0_write(5'd11, 32'h1234);
    cp0_write(5'd9,  32'h1233);
    step(2);
    expect_val("pre_rst_count", F_COUNT, 32'h1234);
    expect_val("pre_rst_ti",    F_TI,    32'h1);
    step(1);
    rst = 1'b1;
    #1;
    expect_val("async_rst_count",   F_COUNT,   32'h0);
    expect_val("async_rst_compare", F_COMPARE, 32'h0);
    expect_val("async_rst_ti",      F_TI,      32'h0);
    expect_val("async_rst_ip",      F_IP,      32'h0);
    expect_val("async_rst_req",     F_REQ,     32'h0);
    expect_val("async_rst_idx",     F_IDX,     32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    step(1);
    expect_val("post_rst_no_tick", F_COUNT, 32'h0);
    step(1);
    expect_val("post_rst_first_tick", F_COUNT, 32'h1);

    // Timer match and interrupt
    status_im = 8'h80; status_ie = 1'b1; status_exl = 1'b0;
    cp0_write(5'd11, 32'd5);
    cp0_write(5'd9,  32'd0);
    step(9);
    expect_val("timer_count9", F_COUNT, 32'd4);
    expect_val("timer_ti9",    F_TI,    32'h0);
    step(1);
    expect_val("timer_count10", F_COUNT, 32'd5);
    expect_val("timer_ti10",    F_TI,    32'h1);
    expect_val("timer_req10",   F_REQ,   32'h0);
    step(1);
    expect_val("timer_req11", F_REQ, 32'h1);
    expect_val("timer_idx11", F_IDX, 32'd7);
    expect_val("timer_ip11",  F_IP,  32'h80);
    cp0_write(5'd11, 32'd9);
    expect_val("ti_clear",      F_TI,      32'h0);
    expect_val("ti_clear_cmp",  F_COMPARE, 32'd9);
    expect_val("req_lag_clear", F_REQ,     32'h1);
    step(1);
    expect_val("req_cleared", F_REQ, 32'h0);

    // Count wrap matching compare=0
    cp0_write(5'd9,  32'hFFFF_FFFF);
    cp0_write(5'd11, 32'h0);
    expect_val("wrap_hold", F_COUNT, 32'hFFFF_FFFF);
    step(1);
    expect_val("wrap_count", F_COUNT, 32'h0);
    expect_val("wrap_ti",    F_TI,    32'h1);

    // COMPARE write on the matching tick: clear wins
    cp0_write(5'd11, 32'h11);
    cp0_write(5'd9,  32'h10);
    step(1);
    cp0_write(5'd11, 32'h11);
    expect_val("collide_cmp_count", F_COUNT, 32'h11);
    expect_val("collide_cmp_ti",    F_TI,    32'h0);

    // COUNT write on a tick edge: write wins
    step(1);
    cp0_write(5'd9, 32'h40);
    expect_val("collide_cnt_count", F_COUNT, 32'h40);
    step(1);
    expect_val("collide_cnt_restart", F_COUNT, 32'h40);
    step(1);
    expect_val("collide_cnt_tick", F_COUNT, 32'h41);

    // Hardware interrupt through the synchroniser
    cp0_write(5'd11, 32'hFFFF_0000);
    status_im = 8'h10;
    step(2);
    expect_val("hw_idle_req", F_REQ, 32'h0);
    hw_int = 6'b000100;
    step(1);
    expect_val("hw_sync1_ip", F_IP, 32'h00);
    step(1);
    expect_val("hw_sync2_ip",  F_IP,  32'h10);
    expect_val("hw_sync2_req", F_REQ, 32'h0);
    step(1);
    expect_val("hw_req", F_REQ, 32'h1);
    expect_val("hw_idx", F_IDX, 32'd4);
    status_exl = 1'b1;
    step(1);
    expect_val("hw_exl_req", F_REQ, 32'h0);
    hw_int = '0;
    status_exl = 1'b0;
    step(4);
    expect_val("hw_release_ip", F_IP, 32'h00);

    // Software interrupts via CAUSE
    status_im = 8'h03;
    cp0_write(5'd13, 32'h300);
    expect_val("sw_ip_set", F_IP,  32'h03);
    expect_val("sw_req_lag", F_REQ, 32'h0);
    step(1);
    expect_val("sw_req", F_REQ, 32'h1);
    expect_val("sw_idx", F_IDX, 32'd1);
    cp0_write(5'd13, 32'h0);
    expect_val("sw_ip_clear", F_IP, 32'h00);
    step(1);
    expect_val("sw_req_clear", F_REQ, 32'h0);
    expect_val("sw_idx_clear", F_IDX, 32'd0);

    // Non-CP0-timer address is ignored
    cp0_write(5'd12, 32'hFFFF_FFFF);
    expect_val("ignored_addr_ip",  F_IP,      32'h00);
    expect_val("ignored_addr_cmp", F_COMPARE, 32'hFFFF_0000);

    step(2);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
